// File: rtl/tlc_left_ped_ctrl.sv
// Two-road traffic light sequencer with protected left-turn phases and an
// optional pedestrian all-red phase (build with TLC_PED_EN to include it).
module tlc_left_ped_ctrl #(
  parameter int TW      = 5,
  parameter int MIN_GRN = 5,
  parameter int MAX_GRN = 20,
  parameter int YEL_T   = 3,
  parameter int LFT_T   = 4,
  parameter int PED_T   = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       lreq_a,
  input  logic       lreq_b,
  input  logic       ped_req,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       walk,
  output logic       phase_done
);

  localparam logic [1:0] L_GRN = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_LFT = 2'b10;
  localparam logic [1:0] L_RED = 2'b11;

  localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GRN - 1);
  localparam logic [TW-1:0] MAX_M1 = TW'(MAX_GRN - 1);
  localparam logic [TW-1:0] YEL_M1 = TW'(YEL_T - 1);
  localparam logic [TW-1:0] LFT_M1 = TW'(LFT_T - 1);

  typedef enum logic [3:0] {
    A_GRN, A_YEL, A_LFT, A_LYEL,
    B_GRN, B_YEL, B_LFT, B_LYEL
`ifdef TLC_PED_EN
    , PED
`endif
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          lft_a_pend;
  logic          lft_b_pend;

`ifdef TLC_PED_EN
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;
  localparam logic [TW-1:0] PED_M1 = TW'(PED_T - 1);

  logic ped_pend;
  logic next_side;
  logic side_next;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  // Next-state: green exits on sensor after the minimum, fixed phases on timer.
  always_comb begin
    state_next = state;
`ifdef TLC_PED_EN
    side_next  = next_side;
`endif
    case (state)
      A_GRN:  if (timer >= MIN_M1 && (!Ta || timer == MAX_M1)) state_next = A_YEL;
      B_GRN:  if (timer >= MIN_M1 && (!Tb || timer == MAX_M1)) state_next = B_YEL;
      A_YEL: begin
        if (timer == YEL_M1) begin
          if (lft_a_pend) state_next = A_LFT;
`ifdef TLC_PED_EN
          else if (ped_pend) begin
            state_next = PED;
            side_next  = SIDE_B;
          end
`endif
          else state_next = B_GRN;
        end
      end
      B_YEL: begin
        if (timer == YEL_M1) begin
          if (lft_b_pend) state_next = B_LFT;
`ifdef TLC_PED_EN
          else if (ped_pend) begin
            state_next = PED;
            side_next  = SIDE_A;
          end
`endif
          else state_next = A_GRN;
        end
      end
      A_LFT:  if (timer == LFT_M1) state_next = A_LYEL;
      B_LFT:  if (timer == LFT_M1) state_next = B_LYEL;
      A_LYEL: begin
        if (timer == YEL_M1) begin
`ifdef TLC_PED_EN
          if (ped_pend) begin
            state_next = PED;
            side_next  = SIDE_B;
          end else
`endif
          state_next = B_GRN;
        end
      end
      B_LYEL: begin
        if (timer == YEL_M1) begin
`ifdef TLC_PED_EN
          if (ped_pend) begin
            state_next = PED;
            side_next  = SIDE_A;
          end else
`endif
          state_next = A_GRN;
        end
      end
`ifdef TLC_PED_EN
      PED:    if (timer == PED_M1) state_next = (next_side == SIDE_A) ? A_GRN : B_GRN;
`endif
      default: state_next = A_GRN;
    endcase
  end

  assign phase_done = (state_next != state);

  // Entry into the serving state wins over a same-cycle request (absorbed).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= A_GRN;
      timer      <= '0;
      lft_a_pend <= 1'b0;
      lft_b_pend <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) timer <= '0;
      else if (timer != '1)    timer <= timer + TW'(1);
      lft_a_pend <= (state_next == A_LFT && state != A_LFT) ? 1'b0 : (lft_a_pend | lreq_a);
      lft_b_pend <= (state_next == B_LFT && state != B_LFT) ? 1'b0 : (lft_b_pend | lreq_b);
    end
  end

`ifdef TLC_PED_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pend  <= 1'b0;
      next_side <= SIDE_B;
    end else begin
      next_side <= side_next;
      ped_pend  <= (state_next == PED && state != PED) ? 1'b0 : (ped_pend | ped_req);
    end
  end
`endif

  always_comb begin
    La   = L_RED;
    Lb   = L_RED;
    walk = 1'b0;
    case (state)
      A_GRN:          La = L_GRN;
      A_YEL, A_LYEL:  La = L_YEL;
      A_LFT:          La = L_LFT;
      B_GRN:          Lb = L_GRN;
      B_YEL, B_LYEL:  Lb = L_YEL;
      B_LFT:          Lb = L_LFT;
`ifdef TLC_PED_EN
      PED:            walk = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tlc_left_ped_ctrl.sv
// Bench for tlc_left_ped_ctrl: directed scenarios plus random traffic, all
// outputs compared each cycle against a phase-level reference model.
module tb_tlc_left_ped_ctrl;

  localparam int MIN_GRN = 5;
  localparam int MAX_GRN = 20;
  localparam int YEL_T   = 3;
  localparam int LFT_T   = 4;
  localparam int PED_T   = 6;

  localparam int K_GRN = 0, K_YEL = 1, K_LFT = 2, K_LYEL = 3, K_PED = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       Ta, Tb, lreq_a, lreq_b, ped_req;
  logic [1:0] La, Lb;
  logic       walk, phase_done;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: phase kind, owning side (0=A,1=B), cycles elapsed, latches
  int m_kind, m_side, m_el, m_ns;
  bit m_lp[2];
  bit m_pp;

  // observation tallies
  logic last_done;
  int   walk_cnt, arrow_cnt;

  tlc_left_ped_ctrl dut (
    .clk(clk), .reset_n(reset_n), .Ta(Ta), .Tb(Tb),
    .lreq_a(lreq_a), .lreq_b(lreq_b), .ped_req(ped_req),
    .La(La), .Lb(Lb), .walk(walk), .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] own_lamp(int k);
    case (k)
      K_GRN:         return 2'b00;
      K_YEL, K_LYEL: return 2'b01;
      K_LFT:         return 2'b10;
      default:       return 2'b11;
    endcase
  endfunction

  function automatic bit ped_on();
`ifdef TLC_PED_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_kind = K_GRN; m_side = 0; m_el = 0; m_ns = 1;
    m_lp[0] = 0; m_lp[1] = 0; m_pp = 0;
  endtask

  function automatic bit model_done(logic ta, logic tb);
    logic t;
    t = (m_side == 0) ? ta : tb;
    case (m_kind)
      K_GRN:         return (m_el >= MIN_GRN - 1) && (!t || m_el == MAX_GRN - 1);
      K_YEL, K_LYEL: return m_el == YEL_T - 1;
      K_LFT:         return m_el == LFT_T - 1;
      default:       return m_el == PED_T - 1;
    endcase
  endfunction

  // Leave a yellow: left (YEL only), else walk, else hand over to the other side.
  task automatic leave_yellow(input bit allow_left, output int nk, output int nside);
    nside = m_side;
    if (allow_left && m_lp[m_side]) nk = K_LFT;
    else if (ped_on() && m_pp) begin
      nk = K_PED; m_ns = 1 - m_side;
    end else begin
      nk = K_GRN; nside = 1 - m_side;
    end
  endtask

  task automatic model_step(input logic ta, tb, ra, rb, rp);
    bit done;
    int nk, nside;
    done  = model_done(ta, tb);
    nk    = m_kind;
    nside = m_side;
    if (done) begin
      case (m_kind)
        K_GRN:  nk = K_YEL;
        K_YEL:  leave_yellow(1, nk, nside);
        K_LFT:  nk = K_LYEL;
        K_LYEL: leave_yellow(0, nk, nside);
        default: begin nk = K_GRN; nside = m_ns; end
      endcase
    end
    for (int s = 0; s < 2; s++) begin
      if (done && nk == K_LFT && nside == s) m_lp[s] = 0;
      else m_lp[s] = m_lp[s] | ((s == 0) ? ra : rb);
    end
    if (ped_on()) m_pp = (done && nk == K_PED) ? 1'b0 : (m_pp | rp);
    m_el   = done ? 0 : m_el + 1;
    m_kind = nk;
    m_side = nside;
  endtask

  // One clock cycle: called just after a falling edge, returns at the next one.
  task automatic drive(input logic ta, tb, ra, rb, rp);
    logic [1:0] ea, eb;
    Ta = ta; Tb = tb; lreq_a = ra; lreq_b = rb; ped_req = rp;
    #1;
    ea = (m_kind == K_PED) ? 2'b11 : (m_side == 0 ? own_lamp(m_kind) : 2'b11);
    eb = (m_kind == K_PED) ? 2'b11 : (m_side == 1 ? own_lamp(m_kind) : 2'b11);
    check("La", 32'(La), 32'(ea));
    check("Lb", 32'(Lb), 32'(eb));
    check("walk", 32'(walk), 32'(m_kind == K_PED));
    check("phase_done", 32'(phase_done), 32'(model_done(ta, tb)));
    last_done = phase_done;
    walk_cnt  += int'(walk);
    arrow_cnt += int'(La == 2'b10 || Lb == 2'b10);
    model_step(ta, tb, ra, rb, rp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    Ta = 0; Tb = 0; lreq_a = 0; lreq_b = 0; ped_req = 0;
    #1;
    check("reset_La", 32'(La), 32'h0);
    check("reset_Lb", 32'(Lb), 32'h3);
    check("reset_walk", 32'(walk), 32'h0);
    check("reset_done", 32'(phase_done), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic ta_r, tb_r;
    reset_n = 1'b0;
    Ta = 0; Tb = 0; lreq_a = 0; lreq_b = 0; ped_req = 0;
    model_reset();
    @(negedge clk);

    // Ta held: green runs to the maximum, then yellow, then B green.
    do_reset();
    for (int i = 0; i < MAX_GRN + YEL_T; i++) drive(1, 0, 0, 0, 0);
    #1;
    check("t1_b_green", 32'({La, Lb}), 32'b1100);
    @(negedge clk);

    // Ta low: minimum green, phase_done on cycles 5 and 8.
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      drive(0, 0, 0, 0, 0);
      check("t2_done_cycle", 32'(last_done), 32'(c == MIN_GRN || c == MIN_GRN + YEL_T));
    end

    // Left request at cycle 2, second request during the arrow.
    do_reset();
    arrow_cnt = 0;
    for (int c = 1; c <= 8; c++) drive(0, 0, c == 2, 0, 0);
    for (int c = 0; c < LFT_T + YEL_T + 16; c++) drive(0, 0, c == 1, 0, 0);
    for (int c = 0; c < 30; c++) drive(0, 0, 0, 0, 0);
    check("t3_arrow_cycles", 32'(arrow_cnt), 32'(2 * LFT_T));

`ifdef TLC_PED_EN
    // Ped and B left both pending during B green.
    do_reset();
    walk_cnt = 0;
    for (int c = 0; c < 10; c++) drive(0, 1, 0, c == 9, c == 9);
    for (int c = 0; c < 40; c++) drive(0, 1, 0, 0, 0);
    check("t4_walk_cycles", 32'(walk_cnt), 32'(PED_T));
`endif

    // Asynchronous reset in B left with latches set.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (m_kind == K_LFT && m_side == 1 && m_el == 1) break;
      drive(0, 0, i == 10, i == 1, i == 10);
    end
    #1;
    check("t5_in_b_left", 32'(Lb), 32'h2);
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_async_La", 32'(La), 32'h0);
    check("t5_async_Lb", 32'(Lb), 32'h3);
    check("t5_async_walk", 32'(walk), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    arrow_cnt = 0; walk_cnt = 0;
    for (int c = 0; c < 40; c++) drive(0, 0, 0, 0, 0);
    check("t5_no_arrow", 32'(arrow_cnt), 32'h0);
    check("t5_no_walk", 32'(walk_cnt), 32'h0);

    // Periodic ped requests (ignored when the walk phase is not built).
    do_reset();
    walk_cnt = 0;
    for (int c = 0; c < 60; c++) drive(c % 7 < 4, 0, 0, 0, c % 10 == 0);
    check("t6_walk_seen", 32'(walk_cnt > 0), 32'(ped_on()));

    // Random traffic.
    do_reset();
    ta_r = 0; tb_r = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(7) == 0) ta_r = ~ta_r;
      if ($urandom_range(7) == 0) tb_r = ~tb_r;
      drive(ta_r, tb_r, $urandom_range(15) == 0, $urandom_range(15) == 0,
            $urandom_range(19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc_left_ped_ctrl.md
Name: tlc_left_ped_ctrl

Overview:
- Sequencing FSM for a two-road intersection (street A, street B) with protected left-turn phases and an optional pedestrian all-red phase.
- Drives the 2-bit lamp codes La/Lb from a registered state plus a phase timer.
- Sits above the lamp decode layer and is the sole owner of light timing in the TLC datapath.

Parameters:
- TW, 5, phase timer width in bits; every duration below must be ≤ 2^TW.
- MIN_GRN, 5, minimum green cycles per side.
- MAX_GRN, 20, maximum green cycles per side while the own-side sensor stays 1.
- YEL_T, 3, yellow duration in cycles; used after both through and left phases.
- LFT_T, 4, protected left-turn duration in cycles.
- PED_T, 6, pedestrian all-red walk duration in cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- Ta  in  1  street A traffic sensor, level.
- Tb  in  1  street B traffic sensor, level.
- lreq_a  in  1  street A left-turn request; a 1-cycle pulse is latched.
- lreq_b  in  1  street B left-turn request; a 1-cycle pulse is latched.
- ped_req  in  1  pedestrian request; a 1-cycle pulse is latched.
- La  out  2  street A lamp: 00 green, 01 yellow, 10 left arrow, 11 red.
- Lb  out  2  street B lamp, same encoding as La.
- walk  out  1  pedestrian walk lamp.
- phase_done  out  1  1-cycle pulse on the last cycle of any phase.

Behaviour:
- Reset, asynchronous on reset_n=0:
  - state=A_GRN, timer=0, all pending latches=0.
  - La=00, Lb=11, walk=0, phase_done=0.
- States: A_GRN, A_YEL, A_LFT, A_LYEL, B_GRN, B_YEL, B_LFT, B_LYEL, PED.
- Outputs are decoded combinationally from the state register only:
  - A_GRN: La=00, Lb=11.
  - A_YEL and A_LYEL: La=01, Lb=11.
  - A_LFT: La=10, Lb=11.
  - B_* states mirror the A_* states with La and Lb swapped.
  - PED: La=11, Lb=11, walk=1. walk=0 in every other state.
- Timer:
  - Clears to 0 on every state transition.
  - Otherwise increments by 1 and saturates at all-ones.
  - A fixed phase of N cycles exits when timer==N-1, so the phase occupies exactly N cycles.
- A_GRN exit: when timer ≥ MIN_GRN-1 and (Ta==0 or timer==MAX_GRN-1), go to A_YEL.
- A_YEL (YEL_T cycles) exit:
  - If lreq_a pending, go to A_LFT.
  - Else if ped pending, go to PED with next_side=B.
  - Else go to B_GRN.
- A_LFT (LFT_T cycles) then A_LYEL (YEL_T cycles), then:
  - If ped pending, go to PED with next_side=B.
  - Else go to B_GRN.
- B_* sequence is symmetric, using Tb and lreq_b, with next_side=A.
- PED (PED_T cycles) exits to the green state of next_side. next_side is a 1-bit register, reset to B.
- phase_done=1 in exactly the cycle in which the state register will change on the next edge.
- Pending latches:
  - Each latch sets on its request pulse.
  - The lreq_a latch clears on the edge entering A_LFT; lreq_b likewise on entry to B_LFT. The ped latch clears on entry to PED.
  - A request in the same cycle as entry to its serving state is absorbed: the latch ends at 0.
  - A request arriving later during the serving phase re-sets the latch and is served in that side's next cycle.
- Simultaneous left and ped pending at a yellow exit: left is served first, PED follows after the left-yellow.
- Sensor changes take effect only after MIN_GRN is reached; sensors are ignored in all other states.
- Reset asserted mid-phase returns immediately, without waiting for a clock edge, to the reset values; any pending latches are lost.

Optional Feature:
- Macro: TLC_PED_EN.
- Defined: PED state, ped latch, next_side register and walk output behave as described above.
- Undefined:
  - ped_req is ignored and walk is tied 0.
  - The PED state and next_side are not built.
  - A_YEL and A_LYEL go directly to B_GRN, B_YEL and B_LYEL go directly to A_GRN, except where a left turn is pending.

Test Plan:
- Reset with Ta=1, Tb=0: La=00, Lb=11 for exactly 20 cycles (MAX_GRN), then La=01 for 3 cycles, then La=11, Lb=00.
- Ta=0 from reset: A green lasts exactly 5 cycles, 3 cycles of yellow follow, and phase_done pulses on cycles 5 and 8.
- lreq_a pulse at cycle 2: after A yellow, La=10 for 4 cycles, then 01 for 3 cycles, then B_GRN; a second lreq_a during A_LFT is served in the next A cycle.
- With TLC_PED_EN: ped_req and lreq_b both pending during B green → B left (Lb=10), B yellow, then PED with walk=1 and La=Lb=11 for 6 cycles, then A_GRN.
- reset_n pulsed low during B_LFT with latches set → outputs are immediately La=00, Lb=11, walk=0, and no left or PED phase follows.
- Without TLC_PED_EN: ped_req pulses every 10 cycles → walk stays 0 and the A/B cycle timing is identical to the run with no requests.
